regfile_mp: RTL

Parametrised multi-read-port integer register file for the RV32 core's decode/writeback boundary. It generalises the single-write, two-read register file in data width, depth and read-port count. It adds a per-register scoreboard (busy bits) for hazard detection and a hardware clear sequencer that zeroes the array after reset or on request. Register 0 is hardwired to zero and never busy.

---
 rtl/regfile_mp.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-read-port integer register file with
// per-register scoreboard (busy bits) and a hardware clear sequencer.
//
// Register 0 is hardwired to zero and is never busy. After reset, or on a
// clr_req pulse, a sweep zeroes registers 1..DEPTH-1 (one per cycle) while
// clr_busy is high; writes, scoreboard sets and further clear requests are
// ignored until the sweep finishes.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write data (and
// the post-write busy bit) to any read port addressing the register being
// written in the same cycle (IDLE only).
//
// Ports:
//   clk      in                 clock, rising edge
//   rst      in                 synchronous reset, active low
//   we       in                 write enable
//   wa       in  [ADDR_W]       write address
//   wd       in  [DATA_W]       write data
//   ra       in  [NUM_RD*ADDR_W] read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd       out [NUM_RD*DATA_W] read data (combinational), port i = rd[i*DATA_W +: DATA_W]
//   rd_busy  out [NUM_RD]       busy bit of each read port's register (combinational)
//   sb_set   in                 mark register sb_addr busy
//   sb_addr  in  [ADDR_W]       scoreboard set address
//   clr_req  in                 request a full clear (single-cycle pulse)
//   clr_busy out                clear sweep in progress

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       sb_set,
    input  logic [ADDR_W-1:0]          sb_addr,
    input  logic                       clr_req,
    output logic                       clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_W-1:0]      clr_ptr;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]       busy;

    logic                   wr_en;
    logic                   sb_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_wa;
    logic [DATA_W-1:0]      mem_wd;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    // NOTE: every variable written here gets a default first, so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_ptr == LAST_ADDR) state_d = ST_IDLE;
            ST_IDLE:  if (clr_req)              state_d = ST_CLEAR;
            default:                            state_d = ST_CLEAR;
        endcase
    end

    // FSM: outputs
    always_comb begin
        clr_busy = (state_q == ST_CLEAR);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // A functional write happens only in IDLE, to a non-zero register, and not
    // in a cycle that also starts a clear (that write is dropped).
    assign wr_en = !clr_busy && we && (wa != '0) && !clr_req;
    assign sb_en = !clr_busy && sb_set && (sb_addr != '0);

    // Single array write port shared between the sweep and normal writes.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = wd;
        if (clr_busy) begin
            mem_we = 1'b1;
            mem_wa = clr_ptr;
            mem_wd = '0;
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_ptr <= FIRST_ADDR;
        end else if (clr_busy) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
        end else if (clr_req) begin
            clr_ptr <= FIRST_ADDR;
        end
    end

    // NOTE: the array has no reset; it is zeroed by the clear sweep instead,
    // which keeps it mappable to plain RAM. Reset still blocks the write so an
    // in-flight write in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Scoreboard. The set is applied after the write-clear so that a set and a
    // write to the same register in one cycle leave it busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else if (clr_busy) begin
            busy[clr_ptr] <= 1'b0;
        end else begin
            if (wr_en) busy[wa]      <= 1'b0;
            if (sb_en) busy[sb_addr] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;
        logic              stored_busy;

        assign addr        = ra[g*ADDR_W +: ADDR_W];
        assign stored      = (addr == '0) ? '0 : mem[addr];
        assign stored_busy = (addr != '0) && busy[addr];

`ifdef REGFILE_BYPASS_EN
        logic hit;
        // wr_en already excludes CLEAR and address 0.
        assign hit = wr_en && (addr == wa);
        assign rd[g*DATA_W +: DATA_W] = hit ? wd : stored;
        assign rd_busy[g]             = hit ? (sb_en && (sb_addr == wa)) : stored_busy;
`else
        assign rd[g*DATA_W +: DATA_W] = stored;
        assign rd_busy[g]             = stored_busy;
`endif
    end

endmodule
